// File: rtl/srt2_div_sequencer.sv
// Control sequencer for the 8-bit SRT radix-2 divider: normalise M, run WIDTH
// signed-digit iterations, correct a negative remainder, then denormalise it.
module srt2_div_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       m_zero,
  input  logic       m_msb,
  input  logic [2:0] a_top,
  output logic       load,
  output logic       lshift_m,
  output logic       lshift_aq,
  output logic       sub,
  output logic       add,
  output logic       q_wr,
  output logic       q_pos,
  output logic       q_neg,
  output logic       q_dec,
  output logic       rshift_a,
  output logic       busy,
  output logic       done,
  output logic       div_zero,
  output logic [3:0] dbg_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_NORM, S_SHIFT, S_OP, S_CORRECT, S_DENORM, S_DONE, S_ERR
  } state_t;

  state_t        state;
  logic [CW-1:0] k;
  logic [CW-1:0] step;
  logic          norm_go;
  logic          digit_pos;
  logic          digit_neg;

  // Keep shifting M up until its MSB is set, capped at WIDTH-1 shifts.
  assign norm_go   = (state == S_NORM) && !m_msb && (k < LAST);
  assign digit_pos = !a_top[2] && (a_top[1] || a_top[0]);
  assign digit_neg = a_top[2] && !(a_top[1] && a_top[0]);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      k     <= '0;
      step  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= m_zero ? S_ERR : S_LOAD;
        end
        S_LOAD: begin
          k     <= '0;
          step  <= '0;
          state <= S_NORM;
        end
        S_NORM: begin
          if (norm_go) k <= k + CW'(1);
          else         state <= S_SHIFT;
        end
        S_SHIFT: state <= S_OP;
        S_OP: begin
          if (step == LAST) begin
            state <= S_CORRECT;
          end else begin
            step  <= step + CW'(1);
            state <= S_SHIFT;
          end
        end
        S_CORRECT: state <= (k != '0) ? S_DENORM : S_DONE;
        S_DENORM: begin
          k <= k - CW'(1);
          if (k == CW'(1)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; NORM, OP and CORRECT also look at
  // the datapath status in the same cycle.
  always_comb begin
    load      = 1'b0;
    lshift_m  = 1'b0;
    lshift_aq = 1'b0;
    sub       = 1'b0;
    add       = 1'b0;
    q_wr      = 1'b0;
    q_pos     = 1'b0;
    q_neg     = 1'b0;
    q_dec     = 1'b0;
    rshift_a  = 1'b0;
    done      = 1'b0;
    div_zero  = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_LOAD: load = 1'b1;
      S_NORM: begin
        lshift_m  = norm_go;
        lshift_aq = norm_go;
      end
      S_SHIFT: lshift_aq = 1'b1;
      S_OP: begin
        q_wr  = 1'b1;
        q_pos = digit_pos;
        q_neg = digit_neg;
        sub   = digit_pos;
        add   = digit_neg;
      end
      S_CORRECT: begin
        add   = a_top[2];
        q_dec = a_top[2];
      end
      S_DENORM: rshift_a = 1'b1;
      S_DONE:   done = 1'b1;
      S_ERR: begin
        done     = 1'b1;
        div_zero = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_srt2_div_sequencer.sv
// Bench for srt2_div_sequencer: cycle-by-cycle expected control traces built
// from the documented sequence, pushed to a queue and compared each cycle.
module tb_srt2_div_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       m_zero;
  logic       m_msb;
  logic [2:0] a_top;
  logic       load, lshift_m, lshift_aq, sub, add, q_wr, q_pos, q_neg;
  logic       q_dec, rshift_a, busy, done, div_zero;
  logic [3:0] dbg_state;

  typedef struct packed {
    logic load, lshift_m, lshift_aq, sub, add, q_wr, q_pos, q_neg;
    logic q_dec, rshift_a, busy, done, div_zero;
  } outs_t;

  typedef struct {
    logic [2:0] a_top;
    logic       sub, add, q_pos, q_neg;
  } digit_vec_t;

  digit_vec_t  dtab[8];
  logic [12:0] exp_q[$];
  int          n_checks;
  int          n_pass;

  srt2_div_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .m_zero(m_zero), .m_msb(m_msb),
    .a_top(a_top), .load(load), .lshift_m(lshift_m), .lshift_aq(lshift_aq),
    .sub(sub), .add(add), .q_wr(q_wr), .q_pos(q_pos), .q_neg(q_neg),
    .q_dec(q_dec), .rshift_a(rshift_a), .busy(busy), .done(done),
    .div_zero(div_zero), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t op_outs(input logic [2:0] at);
    outs_t e;
    e = '0;
    e.busy = 1'b1;
    e.q_wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (dtab[i].a_top == at) begin
        e.sub   = dtab[i].sub;
        e.add   = dtab[i].add;
        e.q_pos = dtab[i].q_pos;
        e.q_neg = dtab[i].q_neg;
      end
    end
    return e;
  endfunction

  // Drive one cycle's inputs, queue its expected outputs, check at negedge.
  task automatic cyc(input logic rst, input logic st, input logic mz,
                     input logic mm, input logic [2:0] at, input outs_t e,
                     input string name, input int c);
    outs_t act;
    logic [12:0] want;
    reset  = rst;
    start  = st;
    m_zero = mz;
    m_msb  = mm;
    a_top  = at;
    exp_q.push_back(e);
    @(negedge clk);
    act  = {load, lshift_m, lshift_aq, sub, add, q_wr, q_pos, q_neg,
            q_dec, rshift_a, busy, done, div_zero};
    want = exp_q.pop_front();
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s cycle %0d: got %b expected %b", name, c, act, want);
    @(posedge clk);
    #1;
  endtask

  // One division: cycle c is the cycle after edge c; c=0 is IDLE with start.
  task automatic run_op(input int k, input logic [7:0][2:0] at_seq,
                        input logic [2:0] corr, input int mid_start,
                        input int abort_at, input string name);
    int    last;
    int    j;
    outs_t e;
    logic  st, mm, rst;
    logic [2:0] at;
    last = (abort_at >= 0) ? abort_at + 3 : 21 + 2 * k;
    for (int c = 0; c <= last; c++) begin
      e   = '0;
      st  = 1'b0;
      mm  = 1'($urandom_range(0, 1));
      rst = 1'b0;
      at  = 3'($urandom_range(0, 7));
      if (c == 0) begin
        st = 1'b1;
      end else if (c == 1) begin
        e.load = 1'b1; e.busy = 1'b1;
      end else if (c <= 1 + k) begin
        mm = 1'b0;
        e.lshift_m = 1'b1; e.lshift_aq = 1'b1; e.busy = 1'b1;
      end else if (c == 2 + k) begin
        mm = (k == 7) ? 1'b0 : 1'b1;
        e.busy = 1'b1;
      end else if (c <= 18 + k) begin
        j = (c - 3 - k) / 2;
        if (((c - 3 - k) % 2) == 0) begin
          e.lshift_aq = 1'b1; e.busy = 1'b1;
        end else begin
          at = at_seq[j];
          e  = op_outs(at);
        end
      end else if (c == 19 + k) begin
        at = corr;
        e.busy = 1'b1; e.add = corr[2]; e.q_dec = corr[2];
      end else if (c <= 19 + 2 * k) begin
        e.rshift_a = 1'b1; e.busy = 1'b1;
      end else if (c == 20 + 2 * k) begin
        e.done = 1'b1; e.busy = 1'b1;
      end
      if (c == mid_start) st = 1'b1;
      if (abort_at >= 0 && c == abort_at) rst = 1'b1;
      if (abort_at >= 0 && c > abort_at) e = '0;
      cyc(rst, st, 1'b0, mm, at, e, name, c);
    end
  endtask

  logic [7:0][2:0] zeros_seq;
  logic [7:0][2:0] mix_seq;
  logic [7:0][2:0] rnd_seq;
  logic [2:0]      mix_list[8];

  initial begin
    dtab[0] = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
    dtab[1] = '{3'b001, 1'b1, 1'b0, 1'b1, 1'b0};
    dtab[2] = '{3'b010, 1'b1, 1'b0, 1'b1, 1'b0};
    dtab[3] = '{3'b011, 1'b1, 1'b0, 1'b1, 1'b0};
    dtab[4] = '{3'b100, 1'b0, 1'b1, 1'b0, 1'b1};
    dtab[5] = '{3'b101, 1'b0, 1'b1, 1'b0, 1'b1};
    dtab[6] = '{3'b110, 1'b0, 1'b1, 1'b0, 1'b1};
    dtab[7] = '{3'b111, 1'b0, 1'b0, 1'b0, 1'b0};
    mix_list = '{3'b001, 3'b110, 3'b000, 3'b011, 3'b100, 3'b111, 3'b010, 3'b101};
    for (int i = 0; i < 8; i++) begin
      zeros_seq[i] = 3'b000;
      mix_seq[i]   = mix_list[i];
      rnd_seq[i]   = 3'($urandom_range(0, 7));
    end
    n_checks = 0;
    n_pass   = 0;

    // Reset held with start high: idle outputs, no operation begins.
    reset = 1'b1; start = 1'b1; m_zero = 1'b0; m_msb = 1'b1; a_top = 3'b000;
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, outs_t'('0), "reset_hold", 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, outs_t'('0), "reset_hold", 1);

    run_op(0, zeros_seq, 3'b000, -1, -1, "k0_zero_digits");
    run_op(3, zeros_seq, 3'b000, -1, -1, "k3_norm");
    run_op(0, mix_seq, 3'b100, -1, -1, "mixed_digits");
    run_op(7, rnd_seq, 3'b011, -1, -1, "k7_cap");

    // Divide by zero: ERR pulse, never LOAD.
    begin
      outs_t e;
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, outs_t'('0), "div_zero", 0);
      e = '0; e.busy = 1'b1; e.done = 1'b1; e.div_zero = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, e, "div_zero", 1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, outs_t'('0), "div_zero", 2);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, outs_t'('0), "div_zero", 3);
    end

    // Start pulse while busy is ignored; reset in the OP of step 4 aborts.
    run_op(2, mix_seq, 3'b000, 6, 14, "abort_step4");
    run_op(1, mix_seq, 3'b110, -1, -1, "after_abort");
    run_op(0, rnd_seq, 3'b111, -1, -1, "final_run");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/srt2_div_sequencer.md
# srt2_div_sequencer

Control sequencer for the 8-bit SRT radix-2 divider in the ALU. It drives the divisor register M (load and left shift), the A:Q partial-remainder/quotient pair, and the adder/subtractor. On a start request it runs the full sequence: normalisation, 8 digit iterations, final correction, remainder denormalisation. It consumes only status bits returned by the datapath; it holds no operand data.

## Interface
- WIDTH, 8, operand width; number of digit iterations; normalisation cap is WIDTH-1.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; one clock, shared with all registers.
- start  in  1  level request; sampled only in IDLE.
- m_zero  in  1  divisor register M is all zeros (valid in IDLE, from operand bus).
- m_msb  in  1  current M[WIDTH-1].
- a_top  in  3  top three bits of partial remainder A {sign, b1, b0}.
- load  out  1  load M and A:Q from operand buses.
- lshift_m  out  1  left-shift M, 0 inserted.
- lshift_aq  out  1  left-shift A:Q as one register.
- sub  out  1  A <= A - M.
- add  out  1  A <= A + M.
- q_wr  out  1  write the current quotient digit into Q[0].
- q_pos, q_neg  out  1  digit +1 / -1; both low means digit 0. Valid with q_wr.
- q_dec  out  1  final quotient correction Q <= Q - 1.
- rshift_a  out  1  logical right shift of A (denormalise remainder).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  one-cycle pulse with done when the divisor is zero.

## Operation
- States: IDLE, LOAD, NORM, SHIFT, OP, CORRECT, DENORM, DONE, ERR.
- Counters:
  - k: normalisation shift count, 0..WIDTH-1.
  - step: 0..WIDTH-1.
- IDLE:
  - start=1 and m_zero=1 → ERR.
  - start=1 and m_zero=0 → LOAD.
  - Otherwise stay in IDLE.
- ERR: done=1, div_zero=1; → IDLE.
- LOAD: load=1; clear k and step; → NORM.
- NORM (Mealy outputs):
  - If m_msb=0 and k<WIDTH-1: lshift_m=1 and lshift_aq=1 in the same cycle, k+1, stay in NORM.
  - Otherwise → SHIFT.
- SHIFT: lshift_aq=1; → OP.
- OP (Mealy on a_top): q_wr=1, and the digit follows a_top:
  - 001, 010, 011: digit +1; sub=1, q_pos=1.
  - 100, 101, 110: digit -1; add=1, q_neg=1.
  - 000, 111: digit 0; no arithmetic.
  - Next state: step=WIDTH-1 → CORRECT; otherwise step+1 → SHIFT.
- CORRECT: if a_top[2]=1, assert add=1 and q_dec=1 together; otherwise no outputs.
  - k>0 → DENORM; k=0 → DONE.
- DENORM: rshift_a=1, k-1; leave to DONE on the cycle where k reaches 0. This gives exactly k rshift_a pulses.
- DONE: done=1; → IDLE.
- Output exclusivity: add and sub are never high together. load never coincides with any shift.
- start is level-sensitive. If start is still high in IDLE after DONE, a new operation begins. start is ignored while busy=1.

## Timing
- Reset:
  - State IDLE, k=0, step=0.
  - Every output is 0 in the cycle after the reset edge, including busy, done and div_zero.
- Edge numbering: edge 1 is the edge that samples start in IDLE. The state after edge 1 is LOAD (or ERR).
- done latency: done is high in the cycle after edge 20+2k, where k = number of normalisation shifts.
  - NORM occupies k+1 cycles.
  - The digit loop occupies 2·WIDTH = 16 cycles.
  - CORRECT occupies 1 cycle.
  - DENORM occupies k cycles.
- Divide by zero: done and div_zero are high in the cycle after edge 1. load is never asserted.
- busy rises with LOAD/ERR and falls with the edge that leaves DONE/ERR.
- Reset mid-operation: IDLE on the next edge, no done pulse, counters cleared. Reset wins over a simultaneous start.
- m_msb never rising: NORM exits after exactly WIDTH-1 = 7 shifts.

## Test plan
- Reset with start=1 held → all outputs 0 and busy=0 for the reset cycle. The operation begins only after reset is released; LOAD follows the first edge without reset.
- start, m_zero=0, m_msb=1, a_top=000 throughout:
  - load at edge 1 only; no lshift_m.
  - 8 lshift_aq/q_wr pairs, no add/sub.
  - No q_dec, no rshift_a; done after edge 20.
- m_msb=0 until 3 shifts are done (divisor 0x17 → 0xB8), then 1:
  - exactly 3 cycles with lshift_m and lshift_aq both high;
  - 3 rshift_a pulses; done after edge 26.
- a_top per OP = 001,110,000,011,100,111,010,101:
  - sub/q_pos on steps 0,3,6; add/q_neg on steps 1,4,7; nothing extra on steps 2,5;
  - a_top=100 in CORRECT → add+q_dec for one cycle.
- start with m_zero=1 → done and div_zero high after edge 1 for one cycle, then IDLE; load never asserted.
- Reset asserted during the OP of step 4 → all outputs 0 next cycle, no done. A start pulse during an earlier busy run is ignored, and the step count on restart begins at 0.
